lzc_norm_pipe: RTL

LZC_NORM_PIPE -- requirements
Module: lzc_norm_pipe

---
 rtl/lzc_norm_pipe.sv | 83 ++++++++
 1 files changed

// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage leading-zero / redundant-sign-bit counter with left normalisation.
// Valid/ready handshake on both sides; S1 holds operand and count, S2 the normalised result.
module lzc_norm_pipe #(
    parameter int WIDTH = 16,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CW-1:0]    o_cnt,
    output logic [WIDTH-1:0] o_norm,
    output logic             o_zero
);

    logic             s2_ready;
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [CW-1:0]    cnt_p1;
    logic             vld_p2;
    logic [CW-1:0]    cnt_p2;
    logic [WIDTH-1:0] norm_p2;
    logic             zero_p2;

    // Sign mode turns the bits below the MSB into "differs from sign" flags and appends a
    // stop bit, so one priority scan serves both modes and caps the sign count at WIDTH-1.
    function automatic logic [CW-1:0] lead_count(input logic [WIDTH-1:0] d, input logic mode);
        logic [WIDTH-1:0] v;
        logic [CW-1:0]    c;
        v = mode ? {d[WIDTH-2:0] ^ {(WIDTH-1){d[WIDTH-1]}}, 1'b1} : d;
        c = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) c = CW'(WIDTH - 1 - i);
        end
        return c;
    endfunction

    assign s2_ready = !vld_p2 || i_ready;
    assign o_ready  = !vld_p1 || s2_ready;

    // Stage 1: operand and count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
        end else if (o_ready) begin
            vld_p1 <= i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (i_valid && o_ready) begin
            data_p1 <= i_data;
            cnt_p1  <= lead_count(i_data, i_mode);
        end
    end

    // Stage 2: normalised result, count and zero flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2  <= 1'b0;
            cnt_p2  <= '0;
            norm_p2 <= '0;
            zero_p2 <= 1'b0;
        end else if (s2_ready) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                cnt_p2  <= cnt_p1;
                norm_p2 <= data_p1 << cnt_p1;
                zero_p2 <= (data_p1 == '0);
            end
        end
    end

    assign o_valid = vld_p2;
    assign o_cnt   = cnt_p2;
    assign o_norm  = norm_p2;
    assign o_zero  = zero_p2;

endmodule
